// File: rtl/if_id_dual_reg_pkg.sv
// Shared pipeline constants for the dual-issue IF/ID register:
// the canonical NOP encoding, the instruction width and the FSM state encoding.
package if_id_dual_reg_pkg;

  localparam int          INSN_WIDTH   = 32;
  localparam logic [31:0] PKG_NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    NORMAL = 1'b0,
    REPLAY = 1'b1
  } ifid_state_e;

endpackage

// File: rtl/if_id_dual_reg_slot.sv
// One IF/ID slot: instruction, PC and valid bit.
// Kill wins over load.
// When neither kill nor load is asserted the slot holds.
// A kill or an invalid load stores the NOP word.
// A kill leaves the PC untouched.
module ifid_slot_reg
  import if_id_dual_reg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INSN   = PKG_NOP_INSN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill,
  input  logic                  load,
  input  logic [INSN_WIDTH-1:0] insn_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  valid_in,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  valid
);

  // Slot storage: reset to an empty NOP slot, then kill > load > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn  <= NOP_INSN;
      pc    <= '0;
      valid <= 1'b0;
    end else if (kill) begin
      insn  <= NOP_INSN;
      valid <= 1'b0;
    end else if (load) begin
      insn  <= valid_in ? insn_in : NOP_INSN;
      pc    <= pc_in;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/if_id_dual_reg.sv
// Dual-slot IF/ID pipeline register with replay of slot 1.
// The FSM has two states, NORMAL and REPLAY.
// A replay moves the un-issued slot 1 into slot 0 for one cycle.
// While that happens, fetch_hold_o keeps fetch from advancing.
// Optional build macro IFID_STAT_EN adds three 32-bit event counters:
// stall cycles, flush cycles and replay entries.
module if_id_dual_reg
  import if_id_dual_reg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INSN   = PKG_NOP_INSN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSN_WIDTH-1:0] f_insn0_i,
  input  logic [INSN_WIDTH-1:0] f_insn1_i,
  input  logic [ADDR_WIDTH-1:0] f_pc0_i,
  input  logic [ADDR_WIDTH-1:0] f_pc1_i,
  input  logic [1:0]            f_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  kill1_i,
  input  logic                  replay_i,
  output logic [INSN_WIDTH-1:0] d_insn0_o,
  output logic [INSN_WIDTH-1:0] d_insn1_o,
  output logic [ADDR_WIDTH-1:0] d_pc0_o,
  output logic [ADDR_WIDTH-1:0] d_pc1_o,
  output logic [1:0]            d_valid_o,
  output logic                  fetch_hold_o,
`ifdef IFID_STAT_EN
  output logic [31:0]           stat_stall_o,
  output logic [31:0]           stat_flush_o,
  output logic [31:0]           stat_replay_o,
`endif
  output logic                  replay_busy_o
);

  ifid_state_e           state;
  ifid_state_e           next_state;
  logic                  replay_take;
  logic                  kill0;
  logic                  load0;
  logic                  kill1;
  logic                  load1;
  logic [INSN_WIDTH-1:0] src_insn0;
  logic [ADDR_WIDTH-1:0] src_pc0;
  logic                  src_valid0;
  logic                  valid0;
  logic                  valid1;

  // A replay is only honoured from NORMAL when there is a valid slot 1 to re-present.
  assign replay_take  = (state == NORMAL) && replay_i && d_valid_o[1];
  assign fetch_hold_o = replay_take || stall_i;
  assign d_valid_o    = {valid1, valid0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= NORMAL;
      replay_busy_o <= 1'b0;
    end else begin
      state         <= next_state;
      replay_busy_o <= (next_state == REPLAY);
    end
  end

  // Next state and slot controls, priority flush > stall > replay > kill1 > load.
  always_comb begin
    next_state = state;
    kill0      = 1'b0;
    load0      = 1'b0;
    kill1      = 1'b0;
    load1      = 1'b0;
    src_insn0  = f_insn0_i;
    src_pc0    = f_pc0_i;
    src_valid0 = f_valid_i[0];
    if (flush_i) begin
      kill0      = 1'b1;
      kill1      = 1'b1;
      next_state = NORMAL;
    end else if (stall_i) begin
      next_state = state;
    end else if (replay_take) begin
      load0      = 1'b1;
      src_insn0  = d_insn1_o;
      src_pc0    = d_pc1_o;
      src_valid0 = valid1;
      kill1      = 1'b1;
      next_state = REPLAY;
    end else if (kill1_i) begin
      load0      = 1'b1;
      kill1      = 1'b1;
      next_state = NORMAL;
    end else begin
      load0      = 1'b1;
      load1      = 1'b1;
      next_state = NORMAL;
    end
  end

  ifid_slot_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NOP_INSN   (NOP_INSN)
  ) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .kill     (kill0),
    .load     (load0),
    .insn_in  (src_insn0),
    .pc_in    (src_pc0),
    .valid_in (src_valid0),
    .insn     (d_insn0_o),
    .pc       (d_pc0_o),
    .valid    (valid0)
  );

  ifid_slot_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NOP_INSN   (NOP_INSN)
  ) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .kill     (kill1),
    .load     (load1),
    .insn_in  (f_insn1_i),
    .pc_in    (f_pc1_i),
    .valid_in (f_valid_i[1]),
    .insn     (d_insn1_o),
    .pc       (d_pc1_o),
    .valid    (valid1)
  );

`ifdef IFID_STAT_EN
  // Event counters.
  // The counters wrap naturally.
  // Stall and flush cycles are counted whatever else is happening.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_o  <= '0;
      stat_flush_o  <= '0;
      stat_replay_o <= '0;
    end else begin
      if (stall_i) begin
        stat_stall_o <= stat_stall_o + 32'd1;
      end
      if (flush_i) begin
        stat_flush_o <= stat_flush_o + 32'd1;
      end
      if (replay_take && !flush_i && !stall_i) begin
        stat_replay_o <= stat_replay_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/if_id_dual_reg.md
IF_ID_DUAL_REG -- requirements
Module: if_id_dual_reg

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, width of each PC.
REQ-002 SHALL have parameter NOP_INSN, 32'h0000_0013, instruction word loaded into any killed or empty slot.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports f_insn0_i / f_insn1_i  in  32 each  fetched instructions for slot 0 and slot 1.
REQ-006 SHALL have ports f_pc0_i / f_pc1_i  in  ADDR_WIDTH each  fetched PCs for slot 0 and slot 1.
REQ-007 SHALL have port f_valid_i  in  2  per-slot fetch valid.
REQ-008 SHALL have port stall_i  in  1  IF/ID hold request from pipeline control.
REQ-009 SHALL have port flush_i  in  1  kill both slots.
REQ-010 SHALL have port kill1_i  in  1  kill slot 1 only.
REQ-011 SHALL have port replay_i  in  1  slot 0 issued and slot 1 not issued; re-present slot 1 as slot 0.
REQ-012 SHALL have ports d_insn0_o / d_insn1_o  out  32 each, d_pc0_o / d_pc1_o  out  ADDR_WIDTH each, d_valid_o  out  2  registered decode-side slots.
REQ-013 SHALL have port fetch_hold_o  out  1  asks fetch to hold its current pair.
REQ-014 SHALL have port replay_busy_o  out  1  high while in REPLAY.

Function
REQ-015 SHALL be a two-state FSM, NORMAL and REPLAY; reset state NORMAL.
REQ-016 SHALL apply per-edge priority: flush_i > stall_i > replay_i > kill1_i > load.
REQ-017 flush_i SHALL force both slots to NOP_INSN, d_valid_o=2'b00, PCs unchanged, FSM to NORMAL, on the same edge, in any state.
REQ-018 stall_i without flush_i SHALL hold all slot registers and the FSM state unchanged.
REQ-019 replay_i in NORMAL with d_valid_o[1]=1 SHALL load slot 0 from slot 1 (insn, pc, valid), set slot 1 to NOP_INSN and invalid, and enter REPLAY.
REQ-020 replay_i with d_valid_o[1]=0 SHALL be ignored and the edge treated as a load.
REQ-021 fetch_hold_o SHALL equal (state==NORMAL && replay_i && d_valid_o[1]) || stall_i, combinationally, so fetch does not advance on a replay edge.
REQ-022 In REPLAY with no flush/stall, the next edge SHALL load both slots from fetch and return to NORMAL; replay_i in REPLAY SHALL be ignored.
REQ-023 kill1_i without higher priority SHALL load slot 0 from fetch and force slot 1 to NOP_INSN, invalid.
REQ-024 A load SHALL copy fetch insn/pc to both slots; an invalid fetch slot SHALL store NOP_INSN with valid 0.
REQ-025 Latency: fetch to decode outputs SHALL be exactly one clock on a load edge.
REQ-026 All outputs SHALL be registered except fetch_hold_o.

Reset
REQ-027 On rst: both insns NOP_INSN, both PCs 0, d_valid_o=2'b00, FSM NORMAL, replay_busy_o=0, all counters 0.
REQ-028 rst asserted mid-REPLAY SHALL abandon the replayed slot with no residual state after release.

Configuration
REQ-029 With IFID_STAT_EN defined: SHALL add outputs stat_stall_o, stat_flush_o, stat_replay_o (32 bits each) counting stall_i cycles, flush_i cycles, and replay entries; wrap modulo 2^32; counters keep counting during stall.
REQ-030 Without IFID_STAT_EN: the ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-031 NOP_INSN value and FSM state encodings (NORMAL=1'b0, REPLAY=1'b1) SHALL live in the shared define file with the other pipeline constants.
REQ-032 One sub-module, ifid_slot_reg (one slot: insn/pc/valid with hold/kill/load), SHALL be instantiated twice.

Verification
REQ-033 Load: f_valid_i=2'b11, insn0=32'h00A00093, insn1=32'h00B00113 -> next edge: both outputs match, d_valid_o=2'b11.
REQ-034 Replay: slots valid, pc1=32'h8000_0004, assert replay_i -> fetch_hold_o=1 that cycle; next edge: d_pc0_o=32'h8000_0004, d_valid_o=2'b01, replay_busy_o=1; following edge: NORMAL, new fetch loaded.
REQ-035 Flush beats stall: flush_i=1 and stall_i=1 together -> next edge: d_valid_o=2'b00, both insns 32'h0000_0013.
REQ-036 Stall hold: stall_i high 3 cycles while fetch changes -> outputs constant; with IFID_STAT_EN, stat_stall_o=3.
REQ-037 kill1_i with fetch valid 2'b11 -> d_valid_o=2'b01, d_insn1_o=32'h0000_0013.
REQ-038 Async reset asserted mid-REPLAY, not on a clock edge -> outputs reach reset values immediately; first edge after release behaves as NORMAL.
